spl_axil_slave_regs: RTL and testbench
======================================

SPL_AXIL_SLAVE_REGS -- requirements
Module: spl_axil_slave_regs

Interface
REQ-001 Parameter C_S_AXI_DATA_WIDTH, default 32: AXI4-Lite data width; only 32 is supported.
REQ-002 Parameter C_S_AXI_ADDR_WIDTH, default 4: byte address width; covers 4 word registers.
REQ-003 S_AXI_ACLK  in  1  the single clock; all state changes on its rising edge.
REQ-004 S_AXI_ARESETN  in  1  reset, asynchronous and active-low.
REQ-005 S_AXI_AWADDR  in  4  write address; S_AXI_AWPROT  in  3  ignored; S_AXI_AWVALID  in  1; S_AXI_AWREADY  out  1.
REQ-006 S_AXI_WDATA  in  32; S_AXI_WSTRB  in  4  byte enables; S_AXI_WVALID  in  1; S_AXI_WREADY  out  1.
REQ-007 S_AXI_BRESP  out  2  write response; S_AXI_BVALID  out  1; S_AXI_BREADY  in  1.
REQ-008 S_AXI_ARADDR  in  4; S_AXI_ARPROT  in  3  ignored; S_AXI_ARVALID  in  1; S_AXI_ARREADY  out  1.
REQ-009 S_AXI_RDATA  out  32; S_AXI_RRESP  out  2; S_AXI_RVALID  out  1; S_AXI_RREADY  in  1.
REQ-010 reg0_out..reg3_out  out  32 each  current register contents to user logic.

Function
REQ-011 The block SHALL decode register index from address bits [3:2]; bits [1:0] ignored.
REQ-012 Write FSM states: IDLE, WAIT_B; AW and W captured independently, in either order or same cycle.
REQ-013 In IDLE, AWREADY SHALL be high until AW captured, then low until BVALID&BREADY; WREADY likewise for W.
REQ-014 On the edge where both AW and W are held, the register SHALL update (bytes with WSTRB=1 only), BVALID SHALL rise, FSM -> WAIT_B.
REQ-015 BVALID SHALL stay high, BRESP=2'b00, until BREADY sampled high; then FSM -> IDLE and AWREADY/WREADY high next cycle.
REQ-016 No new AW or W SHALL be accepted while in WAIT_B.
REQ-017 Read: ARREADY SHALL be high whenever RVALID is low and no AR is pending; AR handshake -> RDATA registered and RVALID high on the next edge.
REQ-018 RVALID, RDATA SHALL hold stable, RRESP=2'b00, until RREADY sampled high; RVALID drops on that edge.
REQ-019 Read latency AR handshake to RVALID = 1 cycle; write latency last of AW/W handshake to BVALID = 1 cycle.
REQ-020 Read and write to same register completing in the same cycle: read SHALL return the pre-write value.
REQ-021 Read and write channels SHALL operate concurrently with no mutual stall.
REQ-022 WSTRB=4'b0000 SHALL complete normally (BVALID asserted) with no register change.
REQ-023 regN_out SHALL reflect the register value the cycle after the write edge.

Reset
REQ-024 ARESETN low SHALL immediately clear reg0..reg3 to 0, AWREADY/WREADY/ARREADY/BVALID/RVALID to 0, RDATA to 0, BRESP/RRESP to 0, FSM to IDLE.
REQ-025 Reset mid-transaction SHALL abandon it with no register update; first cycle after release, AWREADY, WREADY, ARREADY SHALL be 1.

Verification
REQ-026 Write 0x1,0x2,0x3,0x4 to 0x0,0x4,0x8,0xC then read back -> RDATA 0x1..0x4, all RESP OKAY, reg0_out..reg3_out = 1..4.
REQ-027 AWVALID at 0x4 three cycles before WVALID 0xDEADBEEF -> no BVALID until cycle after W handshake; read 0x4 = 0xDEADBEEF.
REQ-028 reg2=0x11223344, write 0xAABBCCDD with WSTRB=4'b0010 -> reg2=0x1122CC44.
REQ-029 BREADY low 5 cycles after write -> BVALID held 5+ cycles, AWREADY/WREADY low throughout, second write accepted only after B handshake.
REQ-030 Same-cycle write 0x55 and read at 0x8 (old 0x7) -> RDATA 0x7; following read -> 0x55.
REQ-031 ARESETN low after AW captured but before W -> no update, all registers read 0, all READY high one cycle after release.

Source files
------------

// File: rtl/spl_axil_slave_regs.sv
// spl_axil_slave_regs
//   AXI4-Lite slave with four 32-bit word registers. Byte strobes are honoured
//   on writes. All responses are OKAY. The read and write channels are
//   independent of each other.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | collecting AW and W, in either order or in the same cycle
//   WAIT_B | register written; BVALID held until BREADY
//
// Ports
//   S_AXI_ACLK, S_AXI_ARESETN   clock, async active-low reset
//   S_AXI_AW*/W*/B*             write address, data and response channels
//   S_AXI_AR*/R*                read address and data channels
//   reg0_out..reg3_out          current register contents for user logic
module spl_axil_slave_regs #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   reg0_out,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   reg1_out,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   reg2_out,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   reg3_out
);

  localparam int NB = C_S_AXI_DATA_WIDTH / 8;

  typedef enum logic {
    IDLE   = 1'b0,
    WAIT_B = 1'b1
  } wr_state_t;

  wr_state_t state_q, state_d;

  logic                          aw_held_q, w_held_q;
  logic [1:0]                    aw_idx_q;
  logic [C_S_AXI_DATA_WIDTH-1:0] wdata_q;
  logic [NB-1:0]                 wstrb_q;

  logic                          aw_hs, w_hs, wr_fire, ar_hs;
  logic [1:0]                    wr_idx;
  logic [C_S_AXI_DATA_WIDTH-1:0] wr_data;
  logic [NB-1:0]                 wr_strb;

  logic [C_S_AXI_DATA_WIDTH-1:0] regs_q [4];
  logic                          rvalid_q;
  logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q;

  // Protection bits and the byte offset within a word have no effect.
  logic unused_inputs;
  assign unused_inputs = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                           S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  // A beat that arrives in the same cycle as its partner is used directly
  // from the bus; an earlier beat comes from its holding register.
  assign wr_idx  = aw_held_q ? aw_idx_q : S_AXI_AWADDR[3:2];
  assign wr_data = w_held_q  ? wdata_q  : S_AXI_WDATA;
  assign wr_strb = w_held_q  ? wstrb_q  : S_AXI_WSTRB;

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) state_q <= IDLE;
    else                state_q <= state_d;
  end

  // The ready outputs are gated by reset so they drop as soon as reset is
  // asserted and come up in the first cycle after it is released.
  always_comb begin
    state_d       = state_q;
    S_AXI_AWREADY = 1'b0;
    S_AXI_WREADY  = 1'b0;
    S_AXI_BVALID  = 1'b0;
    aw_hs         = 1'b0;
    w_hs          = 1'b0;
    wr_fire       = 1'b0;
    case (state_q)
      IDLE: begin
        S_AXI_AWREADY = S_AXI_ARESETN && !aw_held_q;
        S_AXI_WREADY  = S_AXI_ARESETN && !w_held_q;
        aw_hs         = S_AXI_AWVALID && S_AXI_AWREADY;
        w_hs          = S_AXI_WVALID && S_AXI_WREADY;
        if ((aw_held_q || aw_hs) && (w_held_q || w_hs)) begin
          wr_fire = 1'b1;
          state_d = WAIT_B;
        end
      end
      WAIT_B: begin
        S_AXI_BVALID = 1'b1;
        if (S_AXI_BREADY) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      aw_idx_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      for (int i = 0; i < 4; i++) regs_q[i] <= '0;
    end else if (wr_fire) begin
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      for (int b = 0; b < NB; b++)
        if (wr_strb[b]) regs_q[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
    end else begin
      if (aw_hs) begin
        aw_held_q <= 1'b1;
        aw_idx_q  <= S_AXI_AWADDR[3:2];
      end
      if (w_hs) begin
        w_held_q <= 1'b1;
        wdata_q  <= S_AXI_WDATA;
        wstrb_q  <= S_AXI_WSTRB;
      end
    end
  end

  assign S_AXI_ARREADY = S_AXI_ARESETN && !rvalid_q;
  assign ar_hs         = S_AXI_ARVALID && S_AXI_ARREADY;

  // regs_q is sampled before any same-edge write lands, so a colliding
  // read returns the old contents.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else if (ar_hs) begin
      rvalid_q <= 1'b1;
      rdata_q  <= regs_q[S_AXI_ARADDR[3:2]];
    end else if (rvalid_q && S_AXI_RREADY) begin
      rvalid_q <= 1'b0;
    end
  end

  assign S_AXI_RVALID = rvalid_q;
  assign S_AXI_RDATA  = rdata_q;
  assign S_AXI_RRESP  = 2'b00;
  assign S_AXI_BRESP  = 2'b00;

  assign reg0_out = regs_q[0];
  assign reg1_out = regs_q[1];
  assign reg2_out = regs_q[2];
  assign reg3_out = regs_q[3];

endmodule

// File: tb/tb_spl_axil_slave_regs.sv
module tb_spl_axil_slave_regs;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  awaddr = '0, araddr = '0;
  logic [2:0]  awprot = '0, arprot = '0;
  logic        awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        awready, wready, bvalid, arready, rvalid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;
  logic [31:0] r0, r1, r2, r3;
  logic [31:0] reg_out [4];

  always #5 clk = ~clk;

  spl_axil_slave_regs dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .reg0_out(r0), .reg1_out(r1), .reg2_out(r2), .reg3_out(r3)
  );

  assign reg_out[0] = r0;
  assign reg_out[1] = r1;
  assign reg_out[2] = r2;
  assign reg_out[3] = r3;

  int errors = 0;
  int checks = 0;

  // Reference: four words of storage, plus queues of expected responses.
  logic [31:0] model [4];
  logic [31:0] exp_r [$];
  logic [1:0]  exp_b [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, req, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Waits until the selected signal is seen high just before a rising edge,
  // i.e. the handshake completes on that edge. Returns at edge + 1.
  task automatic wait_hs(input int sel, input string name);
    bit hs;
    hs = 1'b0;
    for (int n = 0; n < 50 && !hs; n++) begin
      @(negedge clk);
      case (sel)
        0: hs = awready;
        1: hs = wready;
        2: hs = arready;
        3: hs = bvalid;
        default: hs = rvalid;
      endcase
      step();
    end
    if (!hs) begin
      checks++;
      errors++;
      $display("FAIL timeout %s: handshake not seen within 50 cycles", name);
    end
  endtask

  // Response monitor: a handshake is about to happen on the next edge.
  always @(negedge clk) begin : monitor
    logic [31:0] e;
    logic [1:0]  eb;
    if (rst_n && rvalid && rready) begin
      if (exp_r.size() == 0) begin
        checks++; errors++;
        $display("FAIL r_unexpected: got 0x%08h expected no response", rdata);
      end else begin
        e = exp_r.pop_front();
        chk("rdata", rdata, e);
        chk("rresp", 32'(rresp), 32'h0);
      end
    end
    if (rst_n && bvalid && bready) begin
      if (exp_b.size() == 0) begin
        checks++; errors++;
        $display("FAIL b_unexpected: got bvalid expected no response");
      end else begin
        eb = exp_b.pop_front();
        chk("bresp", 32'(bresp), 32'(eb));
      end
    end
  end

  task automatic do_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int aw_dly, input int w_dly, input int b_dly);
    int idx;
    idx = int'(addr[3:2]);
    fork
      begin
        repeat (aw_dly) step();
        awaddr = addr; awvalid = 1'b1;
        wait_hs(0, "aw");
        awvalid = 1'b0;
      end
      begin
        for (int i = 0; i < w_dly; i++) begin
          @(negedge clk);
          chk("b_early", 32'(bvalid), 32'h0);
          step();
        end
        wdata = data; wstrb = strb; wvalid = 1'b1;
        wait_hs(1, "w");
        wvalid = 1'b0;
      end
    join
    for (int b = 0; b < 4; b++)
      if (strb[b]) model[idx][8*b +: 8] = data[8*b +: 8];
    exp_b.push_back(2'b00);
    @(negedge clk);
    chk("b_latency", 32'(bvalid), 32'h1);
    chk("reg_out", reg_out[idx], model[idx]);
    step();
    for (int i = 0; i < b_dly; i++) begin
      @(negedge clk);
      chk("b_hold", 32'(bvalid), 32'h1);
      chk("awready_in_wait_b", 32'(awready), 32'h0);
      chk("wready_in_wait_b", 32'(wready), 32'h0);
      step();
    end
    bready = 1'b1;
    wait_hs(3, "b");
    bready = 1'b0;
    @(negedge clk);
    chk("awready_after_b", 32'(awready), 32'h1);
    chk("wready_after_b", 32'(wready), 32'h1);
    step();
  endtask

  task automatic do_read(input logic [3:0] addr, input int ar_dly, input int r_dly);
    logic [31:0] held;
    exp_r.push_back(model[int'(addr[3:2])]);
    repeat (ar_dly) step();
    araddr = addr; arvalid = 1'b1;
    wait_hs(2, "ar");
    arvalid = 1'b0;
    @(negedge clk);
    chk("r_latency", 32'(rvalid), 32'h1);
    chk("arready_busy", 32'(arready), 32'h0);
    held = rdata;
    step();
    for (int i = 0; i < r_dly; i++) begin
      @(negedge clk);
      chk("r_hold_valid", 32'(rvalid), 32'h1);
      chk("r_hold_data", rdata, held);
      step();
    end
    rready = 1'b1;
    wait_hs(4, "r");
    rready = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_awready"}, 32'(awready), 32'h0);
    chk({tag, "_wready"}, 32'(wready), 32'h0);
    chk({tag, "_arready"}, 32'(arready), 32'h0);
    chk({tag, "_bvalid"}, 32'(bvalid), 32'h0);
    chk({tag, "_rvalid"}, 32'(rvalid), 32'h0);
    chk({tag, "_rdata"}, rdata, 32'h0);
    for (int i = 0; i < 4; i++) chk({tag, "_reg_out"}, reg_out[i], 32'h0);
  endtask

  task automatic check_ready_after_release(input string tag);
    @(negedge clk);
    chk({tag, "_awready"}, 32'(awready), 32'h1);
    chk({tag, "_wready"}, 32'(wready), 32'h1);
    chk({tag, "_arready"}, 32'(arready), 32'h1);
    step();
  endtask

  initial begin
    for (int i = 0; i < 4; i++) model[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    check_ready_after_release("release");

    // Basic write of each register, then read back
    for (int i = 0; i < 4; i++) do_write(4'(i * 4), 32'(i + 1), 4'hF, 0, 0, 0);
    for (int i = 0; i < 4; i++) do_read(4'(i * 4), 0, 0);
    for (int i = 0; i < 4; i++) chk("basic_reg_out", reg_out[i], 32'(i + 1));

    // AW leads W by three cycles
    do_write(4'h4, 32'hDEADBEEF, 4'hF, 0, 3, 0);
    do_read(4'h4, 0, 1);
    chk("aw_first_reg1", r1, 32'hDEADBEEF);

    // W leads AW
    do_write(4'hC, 32'hCAFE0001, 4'hF, 2, 0, 0);

    // Byte-strobe merge
    do_write(4'h8, 32'h11223344, 4'hF, 0, 0, 0);
    do_write(4'h8, 32'hAABBCCDD, 4'b0010, 0, 0, 0);
    chk("strobe_merge", r2, 32'h1122CC44);

    // Empty strobe completes without changing anything
    do_write(4'h8, 32'hFFFFFFFF, 4'b0000, 1, 0, 0);
    chk("strobe_none", r2, 32'h1122CC44);

    // Long BREADY stall
    do_write(4'h0, 32'h0BAD0BAD, 4'hF, 0, 0, 5);

    // Same-cycle write and read to one register returns the old value
    do_write(4'h8, 32'h7, 4'hF, 0, 0, 0);
    fork
      do_write(4'h8, 32'h55, 4'hF, 0, 0, 0);
      do_read(4'h8, 0, 0);
    join
    do_read(4'h8, 0, 0);
    chk("collide_reg2", r2, 32'h55);

    // Randomized traffic, including concurrent reads and writes to
    // different registers; low address bits are noise.
    for (int t = 0; t < 60; t++) begin
      logic [1:0]  wi, ri;
      logic [31:0] d;
      logic [3:0]  s;
      int kind;
      wi   = 2'($urandom);
      ri   = 2'($urandom);
      d    = $urandom;
      s    = ($urandom_range(0, 4) == 0) ? 4'h0 : 4'($urandom);
      kind = $urandom_range(0, 2);
      if (kind == 0)
        do_write({wi, 2'($urandom)}, d, s, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
      else if (kind == 1 || wi == ri)
        do_read({ri, 2'($urandom)}, $urandom_range(0, 3), $urandom_range(0, 3));
      else
        fork
          do_write({wi, 2'($urandom)}, d, s, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
          do_read({ri, 2'($urandom)}, $urandom_range(0, 3), $urandom_range(0, 3));
        join
    end

    // Reset after AW is captured but before W
    awaddr = 4'h4; awvalid = 1'b1;
    wait_hs(0, "aw_before_reset");
    awvalid = 1'b0;
    @(negedge clk);
    chk("aw_held_awready", 32'(awready), 32'h0);
    chk("aw_held_wready", 32'(wready), 32'h1);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("midreset");
    for (int i = 0; i < 4; i++) model[i] = '0;
    exp_r.delete();
    exp_b.delete();
    step();
    rst_n = 1'b1;
    check_ready_after_release("midrelease");
    for (int i = 0; i < 4; i++) do_read(4'(i * 4), 0, 0);
    do_write(4'h4, 32'h12345678, 4'hF, 0, 0, 0);
    do_read(4'h4, 0, 0);

    repeat (3) step();
    chk("r_queue_drained", 32'(exp_r.size()), 32'h0);
    chk("b_queue_drained", 32'(exp_b.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
